dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for an RV32I memory stage.
// Accepts one load/store in IDLE, waits LATENCY edges, then presents a single-cycle
// response. Byte/half/word accesses with RV32I funct3 encoding, little-endian.
// Misaligned accesses and unknown funct3 values return err=1, rdata=0, no write.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  request present          req_ready  accepting (IDLE only)
//   we         1 = store, 0 = load      funct3     access size / sign
//   addr       byte address             wdata      right-aligned store data
//   rvalid     one-cycle response       rdata      extended load data (held)
//   err        error response (held)    stall      req_valid && state != RESP
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Word array; deliberately not reset.
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d;
  logic          mem_we;

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;
  logic [31:0]   st_data;
  logic [3:0]    be;
  logic          legal;
  logic          finish;

  // Address bits above the array size wrap away.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign idx  = addr_q[AW+1:2];
  assign word = mem_q[idx];
  assign ld_h = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_b = word[7:0];
      2'd1:    ld_b = word[15:8];
      2'd2:    ld_b = word[23:16];
      default: ld_b = word[31:24];
    endcase
  end

  // Access decode on the captured request.
  always_comb begin
    legal   = 1'b0;
    ld_data = 32'd0;
    be      = 4'd0;
    st_data = wdata_q;
    case (f3_q)
      3'b000: begin
        legal   = 1'b1;
        ld_data = {{24{ld_b[7]}}, ld_b};
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        legal   = ~addr_q[0];
        ld_data = {{16{ld_h[15]}}, ld_h};
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        legal   = (addr_q[1:0] == 2'd0);
        ld_data = word;
        be      = 4'b1111;
      end
      // Unsigned variants exist for loads only.
      3'b100: begin
        legal   = ~we_q;
        ld_data = {24'd0, ld_b};
      end
      3'b101: begin
        legal   = ~we_q & ~addr_q[0];
        ld_data = {16'd0, ld_h};
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      mem_d[i*8 +: 8] = be[i] ? st_data[i*8 +: 8] : word[i*8 +: 8];
  end

  // WAIT->RESP edge: store commits and load data registers together.
  assign finish = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we = finish && legal && we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          err_d   = ~legal;
          rdata_d = (legal && !we_q) ? ld_data : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset leaves state IDLE, so an abandoned store can never reach mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_d;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rvalid    = (state_q == S_RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign stall     = req_valid && (state_q != S_RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=256, LATENCY=2).
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One request: accept, time the response, check data/err, then check that
  // rvalid drops after one cycle while rdata/err hold.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bit seen;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1 seen = rvalid;
    end
    chk({tag, ".lat"}, 32'(n), 32'(LATENCY));
    chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    chk({tag, ".rv1"}, 32'(rvalid), 32'd0);
    chk({tag, ".hold"}, rdata, exp_rd);
    chk({tag, ".herr"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [2:0] exp_b;
    reset = 1'b0; req_valid = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    #1;
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.err",    32'(err),    32'd0);
    chk("rst.rdata",  rdata,       32'd0);
    chk("rst.ready",  32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("idle.stall0", 32'(stall), 32'd0);
    req_valid = 1'b1;
    #1 chk("idle.stall1", 32'(stall), 32'd1);
    req_valid = 1'b0;

    // Word store/load, then byte store and sub-word loads.
    xact("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sb11",  1'b1, 3'b000, 32'h11, 32'h80, 32'h0, 1'b0);
    xact("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h00000080, 1'b0);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
    xact("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

    // Errors: misaligned half store writes nothing; reserved load funct3.
    xact("sh13",  1'b1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1'b1);
    xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
    xact("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("lw11",  1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
    xact("sh12",  1'b1, 3'b001, 32'h12, 32'h1234, 32'h0, 1'b0);
    xact("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123480EF, 1'b0);

    // req_valid held: per accept, WAIT x LATENCY, RESP, then IDLE accepts again,
    // i.e. each accepting edge is followed by LATENCY+1 non-accepting edges.
    // Packed as {stall, req_ready, rvalid}.
    @(negedge clk);
    req_valid = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      case (k % 4)
        0:       exp_b = 3'b110;
        3:       exp_b = 3'b001;
        default: exp_b = 3'b100;
      endcase
      #1;
      chk($sformatf("b2b.k%0d", k), 32'({stall, req_ready, rvalid}), 32'(exp_b));
      if (k % 4 == 3) chk($sformatf("b2b.rd%0d", k), rdata, 32'h123480EF);
    end
    req_valid = 1'b0;

    // Reset in WAIT abandons the store.
    xact("sw20a", 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid.rvalid", 32'(rvalid), 32'd0);
    chk("mid.ready",  32'(req_ready), 32'd1);
    chk("mid.rdata",  rdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk($sformatf("mid.rv%0d", k), 32'(rvalid), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // Address wrap modulo 4*DEPTH.
    xact("sw400", 1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 1'b0);
    xact("lw0",   1'b0, 3'b010, 32'h0,   32'h0, 32'h12345678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
